// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared constants for the mux_sel_rr channel selector.
//   MODE_FIXED : value of the mode input that selects the channel given by sel
//   MODE_RR    : value of the mode input that selects circular round-robin
// -----------------------------------------------------------------------------
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage : mux_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational circular priority search. Starting at channel ptr, it
// returns the first requesting channel in the order
// ptr, ptr+1, ..., CH-1, 0, ..., ptr-1.
//
// Parameters:
//   CH      : number of request lines (2..16, need not be a power of two)
//   SELW    : width of channel indices
// Ports:
//   req     : in  [CH-1:0]   per-channel request
//   ptr     : in  [SELW-1:0] highest-priority channel (must be < CH)
//   gnt_vld : out            at least one request present
//   gnt_idx : out [SELW-1:0] granted channel (0 when gnt_vld=0)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int CH   = 4,
    parameter int SELW = $clog2(CH)
) (
    input  logic [CH-1:0]   req,
    input  logic [SELW-1:0] ptr,
    output logic            gnt_vld,
    output logic [SELW-1:0] gnt_idx
);

    // cand_idx[k] is the channel examined at search step k.
    logic [SELW-1:0] cand_idx [CH];
    logic [CH-1:0]   cand_req;

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_cand
            // One extra bit so ptr+k cannot overflow before the modulo step.
            logic [SELW:0] sum;
            assign sum          = {1'b0, ptr} + (SELW+1)'(gi);
            // ptr < CH and k < CH, so a single subtraction is a full modulo.
            assign cand_idx[gi] = (sum >= (SELW+1)'(CH)) ? SELW'(sum - (SELW+1)'(CH))
                                                         : sum[SELW-1:0];
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Walk from the last step back to step 0 so the earliest step wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = CH - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand_idx[k];
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/mux_sel_rr.sv
// -----------------------------------------------------------------------------
// mux_sel_rr
// Selects one of CH valid/ready input channels into a single registered
// output stage. mode=0 takes the channel given by sel; mode=1 serves channels
// round-robin starting after the last served channel.
//
// Parameters:
//   WIDTH : data bits per channel
//   CH    : input channel count (2..16)
//   SELW  : channel index width
// Ports:
//   clk      : in                 clock, rising edge
//   rst_n    : in                 asynchronous active-low reset
//   mode     : in                 0 fixed select, 1 round-robin
//   sel      : in  [SELW-1:0]     channel used in fixed mode (>= CH grants none)
//   din      : in  [CH*WIDTH-1:0] channel i at [i*WIDTH +: WIDTH]
//   din_vld  : in  [CH-1:0]       per-channel valid
//   din_rdy  : out [CH-1:0]       per-channel ready (combinational, one-hot/zero)
//   dout     : out [WIDTH-1:0]    registered selected data
//   dout_vld : out                dout holds an unconsumed beat
//   dout_ch  : out [SELW-1:0]     source channel of dout
//   dout_rdy : in                 downstream accepts dout
// -----------------------------------------------------------------------------
module mux_sel_rr
    import mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CH    = 4,
    parameter int SELW  = $clog2(CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mode,
    input  logic [SELW-1:0]     sel,
    input  logic [CH*WIDTH-1:0] din,
    input  logic [CH-1:0]       din_vld,
    output logic [CH-1:0]       din_rdy,
    output logic [WIDTH-1:0]    dout,
    output logic                dout_vld,
    output logic [SELW-1:0]     dout_ch,
    input  logic                dout_rdy
);

    logic [WIDTH-1:0] dout_reg;
    logic             dout_vld_reg;
    logic [SELW-1:0]  dout_ch_reg;
    logic [SELW-1:0]  ptr_reg;
    logic [SELW-1:0]  ptr_next;

    logic             load_en;
    logic             rr_vld;
    logic [SELW-1:0]  rr_idx;
    logic             fix_vld;
    logic             gnt_vld;
    logic [SELW-1:0]  gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic             transfer;

    // The output stage can take a new beat when empty or being drained.
    assign load_en = !dout_vld_reg || dout_rdy;

    rr_arbiter #(
        .CH   (CH),
        .SELW (SELW)
    ) u_rr_arbiter (
        .req     (din_vld),
        .ptr     (ptr_reg),
        .gnt_vld (rr_vld),
        .gnt_idx (rr_idx)
    );

    // Fixed mode: an out-of-range sel matches no channel and grants nothing.
    always_comb begin
        fix_vld = 1'b0;
        for (int i = 0; i < CH; i++) begin
            if ((sel == SELW'(i)) && din_vld[i]) begin
                fix_vld = 1'b1;
            end
        end
    end

    assign gnt_vld = (mode == MODE_RR) ? rr_vld : fix_vld;
    assign gnt_idx = (mode == MODE_RR) ? rr_idx : sel;

    // Ready is also held low during reset so no beat is accepted upstream.
    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_rdy
            assign din_rdy[gi] = rst_n && load_en && gnt_vld && (gnt_idx == SELW'(gi));
        end
    endgenerate

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < CH; i++) begin
            if (gnt_idx == SELW'(i)) begin
                gnt_data = din[i*WIDTH +: WIDTH];
            end
        end
    end

    assign transfer = |(din_vld & din_rdy);

    // Pointer moves to the channel after the one just served, wrapping at CH-1
    // so it never leaves 0..CH-1 for non-power-of-two CH.
    assign ptr_next = (gnt_idx == SELW'(CH - 1)) ? '0 : gnt_idx + SELW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_reg     <= '0;
            dout_ch_reg  <= '0;
            dout_vld_reg <= 1'b0;
            ptr_reg      <= '0;
        end else begin
            if (transfer) begin
                dout_reg     <= gnt_data;
                dout_ch_reg  <= gnt_idx;
                dout_vld_reg <= 1'b1;
                if (mode == MODE_RR) begin
                    ptr_reg <= ptr_next;
                end
            end else if (dout_rdy) begin
                dout_vld_reg <= 1'b0;
            end
        end
    end

    assign dout     = dout_reg;
    assign dout_ch  = dout_ch_reg;
    assign dout_vld = dout_vld_reg;

endmodule : mux_sel_rr

// File: tb/tb_mux_sel_rr.sv
// Directed bench for mux_sel_rr: a CH=4 instance for the main scenarios and a
// CH=3 instance for the out-of-range select and non-power-of-two wrap.
module tb_mux_sel_rr;

    logic clk;
    logic rst_n;

    // CH=4 instance
    logic        mode4;
    logic [1:0]  sel4;
    logic [31:0] din4;
    logic [3:0]  din_vld4;
    logic [3:0]  din_rdy4;
    logic [7:0]  dout4;
    logic        dout_vld4;
    logic [1:0]  dout_ch4;
    logic        dout_rdy4;

    // CH=3 instance
    logic        mode3;
    logic [1:0]  sel3;
    logic [23:0] din3;
    logic [2:0]  din_vld3;
    logic [2:0]  din_rdy3;
    logic [7:0]  dout3;
    logic        dout_vld3;
    logic [1:0]  dout_ch3;
    logic        dout_rdy3;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mux_sel_rr #(.WIDTH(8), .CH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .mode(mode4), .sel(sel4),
        .din(din4), .din_vld(din_vld4), .din_rdy(din_rdy4),
        .dout(dout4), .dout_vld(dout_vld4), .dout_ch(dout_ch4), .dout_rdy(dout_rdy4)
    );

    mux_sel_rr #(.WIDTH(8), .CH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
        .din(din3), .din_vld(din_vld3), .din_rdy(din_rdy3),
        .dout(dout3), .dout_vld(dout_vld3), .dout_ch(dout_ch3), .dout_rdy(dout_rdy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mode4 = 1'b1; sel4 = 2'd0; din4 = 32'h44332211; din_vld4 = 4'b1111; dout_rdy4 = 1'b1;
        mode3 = 1'b0; sel3 = 2'd0; din3 = 24'hC2C1C0;   din_vld3 = 3'b000;  dout_rdy3 = 1'b1;
        #3;
        total_cnt++;
        if (din_rdy4 !== 4'b0000) $display("FAIL reset_din_rdy got=%b exp=0000", din_rdy4);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({dout_vld4, dout_ch4, dout4} !== 11'd0)
            $display("FAIL reset_outputs got vld=%b ch=%0d dout=%h exp all 0", dout_vld4, dout_ch4, dout4);
        else pass_cnt++;
        total_cnt++;
        if (dout_vld3 !== 1'b0) $display("FAIL reset_vld3 got=%b exp=0", dout_vld3);
        else pass_cnt++;
        din_vld4 = 4'b0000;
        #2 rst_n = 1'b1;
        step();
        $display("reset: outputs cleared");
    endtask

    task automatic test_fixed();
        mode4 = 1'b0; sel4 = 2'd2; din4 = 32'h33A51100; din_vld4 = 4'b0100; dout_rdy4 = 1'b1;
        #1;
        total_cnt++;
        if (din_rdy4 !== 4'b0100) $display("FAIL fixed_din_rdy got=%b exp=0100", din_rdy4);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({dout_vld4, dout_ch4, dout4} !== {1'b1, 2'd2, 8'hA5})
            $display("FAIL fixed_beat got vld=%b ch=%0d dout=%h exp vld=1 ch=2 dout=a5", dout_vld4, dout_ch4, dout4);
        else pass_cnt++;
        $display("fixed: sel=2 dout=%h ch=%0d", dout4, dout_ch4);
        // Other channels valid but not selected: nothing granted.
        din_vld4 = 4'b1011;
        #1;
        total_cnt++;
        if (din_rdy4 !== 4'b0000) $display("FAIL fixed_unsel_rdy got=%b exp=0000", din_rdy4);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({dout_vld4, dout4} !== {1'b0, 8'hA5})
            $display("FAIL fixed_drain got vld=%b dout=%h exp vld=0 dout=a5", dout_vld4, dout4);
        else pass_cnt++;
        din_vld4 = 4'b0000;
    endtask

    task automatic test_rr_fair();
        logic [1:0] exp_ch [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        mode4 = 1'b1; din4 = 32'h13121110; din_vld4 = 4'b1111; dout_rdy4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            total_cnt++;
            if ({dout_vld4, dout_ch4, dout4} !== {1'b1, exp_ch[i], 8'h10 + 8'(exp_ch[i])})
                $display("FAIL rr_fair[%0d] got vld=%b ch=%0d dout=%h exp ch=%0d", i, dout_vld4, dout_ch4, dout4, exp_ch[i]);
            else pass_cnt++;
            $display("rr_fair: beat %0d ch=%0d dout=%h", i, dout_ch4, dout4);
        end
        din_vld4 = 4'b0000;
        step();  // ptr now 1
    endtask

    task automatic test_skip_wrap();
        logic [3:0] exp_rdy [3] = '{4'b0001, 4'b0100, 4'b0001};
        mode4 = 1'b1; din4 = 32'h23222120; dout_rdy4 = 1'b1;
        // From ptr=1, only ch2 valid: grants 2, leaving ptr=3.
        din_vld4 = 4'b0100;
        step();
        total_cnt++;
        if (dout_ch4 !== 2'd2) $display("FAIL skip_setup got ch=%0d exp=2", dout_ch4);
        else pass_cnt++;
        din_vld4 = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++;
            if (din_rdy4 !== exp_rdy[i]) $display("FAIL skip_rdy[%0d] got=%b exp=%b", i, din_rdy4, exp_rdy[i]);
            else pass_cnt++;
            step();
            total_cnt++;
            if (dout4 !== ((exp_rdy[i] == 4'b0001) ? 8'h20 : 8'h22))
                $display("FAIL skip_dout[%0d] got=%h ch=%0d", i, dout4, dout_ch4);
            else pass_cnt++;
            $display("skip_wrap: beat %0d ch=%0d", i, dout_ch4);
        end
        din_vld4 = 4'b0000;
        step();  // ptr now 1
    endtask

    task automatic test_backpressure();
        mode4 = 1'b1; din4 = 32'h33221100 | 32'h00001100; dout_rdy4 = 1'b1;
        din4 = 32'h33000011 << 0;
        din4 = {8'h33, 8'h22, 8'h11, 8'h00};
        din_vld4 = 4'b0010;
        step();
        total_cnt++;
        if ({dout_vld4, dout_ch4, dout4} !== {1'b1, 2'd1, 8'h11})
            $display("FAIL bp_first got vld=%b ch=%0d dout=%h exp ch=1 dout=11", dout_vld4, dout_ch4, dout4);
        else pass_cnt++;
        dout_rdy4 = 1'b0;
        din_vld4 = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++;
            if (din_rdy4 !== 4'b0000) $display("FAIL bp_rdy[%0d] got=%b exp=0000", i, din_rdy4);
            else pass_cnt++;
            step();
            total_cnt++;
            if ({dout_vld4, dout_ch4, dout4} !== {1'b1, 2'd1, 8'h11})
                $display("FAIL bp_hold[%0d] got vld=%b ch=%0d dout=%h exp ch=1 dout=11", i, dout_vld4, dout_ch4, dout4);
            else pass_cnt++;
            $display("backpressure: stall %0d dout=%h", i, dout4);
        end
        dout_rdy4 = 1'b1;
        #1;
        total_cnt++;
        if (din_rdy4 !== 4'b1000) $display("FAIL bp_release_rdy got=%b exp=1000", din_rdy4);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({dout_vld4, dout_ch4, dout4} !== {1'b1, 2'd3, 8'h33})
            $display("FAIL bp_release got vld=%b ch=%0d dout=%h exp ch=3 dout=33", dout_vld4, dout_ch4, dout4);
        else pass_cnt++;
        din_vld4 = 4'b0000;
        step();  // ptr now 0
    endtask

    task automatic test_reset_mid();
        mode4 = 1'b1; din4 = {8'h43, 8'h42, 8'h41, 8'h40}; dout_rdy4 = 1'b0;
        din_vld4 = 4'b0100;
        step();  // ch2 held, ptr=3
        total_cnt++;
        if ({dout_vld4, dout_ch4} !== {1'b1, 2'd2}) $display("FAIL rmid_setup got vld=%b ch=%0d exp vld=1 ch=2", dout_vld4, dout_ch4);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({dout_vld4, dout_ch4, dout4, din_rdy4} !== 15'd0)
            $display("FAIL rmid_async got vld=%b ch=%0d dout=%h rdy=%b exp all 0", dout_vld4, dout_ch4, dout4, din_rdy4);
        else pass_cnt++;
        din_vld4 = 4'b1111; dout_rdy4 = 1'b1;
        step();
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (din_rdy4 !== 4'b0001) $display("FAIL rmid_rdy got=%b exp=0001", din_rdy4);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({dout_vld4, dout_ch4, dout4} !== {1'b1, 2'd0, 8'h40})
            $display("FAIL rmid_first got vld=%b ch=%0d dout=%h exp ch=0 dout=40", dout_vld4, dout_ch4, dout4);
        else pass_cnt++;
        $display("reset_mid: first grant ch=%0d", dout_ch4);
        din_vld4 = 4'b0000;
        step();
    endtask

    task automatic test_ch3();
        logic [1:0] exp_ch [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
        mode3 = 1'b0; sel3 = 2'd1; din3 = {8'hC2, 8'hC1, 8'hC0}; din_vld3 = 3'b010; dout_rdy3 = 1'b1;
        step();
        total_cnt++;
        if ({dout_vld3, dout_ch3, dout3} !== {1'b1, 2'd1, 8'hC1})
            $display("FAIL ch3_load got vld=%b ch=%0d dout=%h exp ch=1 dout=c1", dout_vld3, dout_ch3, dout3);
        else pass_cnt++;
        sel3 = 2'd3; din_vld3 = 3'b111; dout_rdy3 = 1'b0;
        step();
        total_cnt++;
        if ({dout_vld3, dout3} !== {1'b1, 8'hC1}) $display("FAIL ch3_hold got vld=%b dout=%h exp vld=1 dout=c1", dout_vld3, dout3);
        else pass_cnt++;
        dout_rdy3 = 1'b1;
        #1;
        total_cnt++;
        if (din_rdy3 !== 3'b000) $display("FAIL ch3_sel3_rdy got=%b exp=000", din_rdy3);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({dout_vld3, dout_ch3, dout3} !== {1'b0, 2'd1, 8'hC1})
            $display("FAIL ch3_sel3_drain got vld=%b ch=%0d dout=%h exp vld=0 ch=1 dout=c1", dout_vld3, dout_ch3, dout3);
        else pass_cnt++;
        $display("ch3: sel=3 drained vld=%b", dout_vld3);
        mode3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total_cnt++;
            if ({dout_vld3, dout_ch3, dout3} !== {1'b1, exp_ch[i], 8'hC0 + 8'(exp_ch[i])})
                $display("FAIL ch3_rr[%0d] got vld=%b ch=%0d dout=%h exp ch=%0d", i, dout_vld3, dout_ch3, dout3, exp_ch[i]);
            else pass_cnt++;
            $display("ch3_rr: beat %0d ch=%0d", i, dout_ch3);
        end
        din_vld3 = 3'b000;
        step();
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_rr_fair();
        test_skip_wrap();
        test_backpressure();
        test_reset_mid();
        test_ch3();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_mux_sel_rr

// File: doc/mux_sel_rr.md
MUX_SEL_RR -- requirements
Module: mux_sel_rr

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per channel.
REQ-002 SHALL have parameter CH, default 4, input channel count (2..16).
REQ-003 SHALL have parameter SELW, default $clog2(CH), select/channel-index width.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port mode  input  1  0 = fixed select, 1 = round-robin.
REQ-007 SHALL have port sel  input  SELW  channel index used in fixed mode.
REQ-008 SHALL have port din  input  CH*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port din_vld  input  CH  per-channel valid.
REQ-010 SHALL have port din_rdy  output  CH  per-channel ready, combinational.
REQ-011 SHALL have port dout  output  WIDTH  registered selected data.
REQ-012 SHALL have port dout_vld  output  1  dout holds an unconsumed beat.
REQ-013 SHALL have port dout_ch  output  SELW  source channel of dout.
REQ-014 SHALL have port dout_rdy  input  1  downstream accepts dout.

Function
REQ-015 SHALL define load_en = !dout_vld || dout_rdy; output register reloads only when load_en is 1.
REQ-016 SHALL, in mode 0, grant channel sel iff din_vld[sel]=1; sel >= CH SHALL grant nothing.
REQ-017 SHALL, in mode 1, grant the first channel with din_vld=1 searching circularly from ptr (ptr, ptr+1, ..., CH-1, 0, ..., ptr-1).
REQ-018 SHALL drive din_rdy[g]=load_en for granted channel g, all other din_rdy bits 0; din_rdy SHALL be one-hot or zero.
REQ-019 SHALL treat din_vld[g] && din_rdy[g] as a transfer; on transfer at edge, dout<=din channel g, dout_ch<=g, dout_vld<=1.
REQ-020 SHALL clear dout_vld when dout_rdy=1 and no transfer occurs in that cycle; dout and dout_ch SHALL then hold their last values.
REQ-021 SHALL hold dout, dout_ch, dout_vld stable while dout_vld=1 and dout_rdy=0.
REQ-022 SHALL have latency exactly 1 cycle: beat accepted at edge N appears on dout after edge N; full throughput one beat per cycle when dout_rdy=1.
REQ-023 SHALL, in mode 1, update ptr to (g+1) mod CH on each transfer; ptr wraps CH-1 -> 0; ptr unchanged without transfer.
REQ-024 SHALL leave ptr unchanged in mode 0; mode change takes effect on the same-cycle combinational grant, ptr retained across mode changes.
REQ-025 SHALL hold din_vld-independent grant: a channel deasserting din_vld before transfer loses grant with no state change.
REQ-026 SHALL support non-power-of-two CH; ptr SHALL never exceed CH-1.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force dout=0, dout_ch=0, dout_vld=0, ptr=0.
REQ-028 SHALL discard any held beat on reset mid-operation; din_rdy SHALL be all-zero while rst_n=0.
REQ-029 SHALL resume on first rising clk edge after rst_n deasserts with round-robin search from channel 0.

Structure
REQ-030 SHALL place MODE_FIXED=1'b0 and MODE_RR=1'b1 constants in shared package mux_pkg.
REQ-031 SHALL implement circular priority search as sub-module rr_arbiter (inputs req[CH], ptr; outputs gnt_vld, gnt_idx).
REQ-032 SHALL keep output register and ptr in mux_sel_rr top; no other storage.

Verification
REQ-033 SHALL test fixed mode: CH=4, WIDTH=8, sel=2, din ch2=8'hA5, din_vld=4'b0100, dout_rdy=1 -> next cycle dout=A5, dout_ch=2, dout_vld=1; din_rdy=4'b0100.
REQ-034 SHALL test round-robin fairness: mode=1, din_vld=4'b1111 steady, dout_rdy=1 -> dout_ch sequence 0,1,2,3,0 on consecutive cycles.
REQ-035 SHALL test skipping and wrap: mode=1, ptr=3, din_vld=4'b0101 -> grant 0, then 2, then 0; ch1/ch3 never granted.
REQ-036 SHALL test backpressure: dout_vld=1, dout_rdy=0 for 3 cycles -> din_rdy=0, dout/dout_ch unchanged; dout_rdy=1 -> pending beat loads same cycle.
REQ-037 SHALL test reset mid-operation: rst_n low between clock edges with dout_vld=1 -> dout_vld=0, dout=0 immediately; after release first RR grant starts at ch0.
REQ-038 SHALL test CH=3, sel=3 in fixed mode -> din_rdy=0, dout_vld falls to 0 after dout_rdy=1.
